// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: prioritises EX exceptions, IRQs and ERET, sequences flush/EPC/redirect, owns CP0 Status/Cause.
// Optional macro EXC_IRQ_MASK_EN makes Status.IM writable and applies it to interrupts.
module exc_ctrl #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0008,
    parameter int unsigned NUM_IRQ     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               stall,
    input  logic [31:0]        ex_pc,
    input  logic               ex_valid,
    input  logic               ex_ovf,
    input  logic               ex_ri,
    input  logic               ex_syscall,
    input  logic               mem_eret,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    input  logic [31:0]        epc_q,
    output logic [31:0]        epc_d,
    output logic               flush,
    output logic               pc_redirect,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        status,
    output logic [31:0]        cause,
    output logic               busy
);

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;
    localparam logic [4:0] EXC_RI     = 5'd10;
    localparam logic [4:0] EXC_OV     = 5'd12;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLUSH      = 2'd1,
        ERET_FLUSH = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    state_t             state, next_state;
    logic               ie, exl;
    logic [7:0]         im;
    logic [NUM_IRQ-1:0] im_eff;
    logic [NUM_IRQ-1:0] ip;
    logic [4:0]         exc_code, exc_code_n;
    logic [31:0]        cap_pc, target_pc;
    logic               take_exc, take_eret, irq_pend, status_we;
    logic               unused_ok;

`ifdef EXC_IRQ_MASK_EN
    always_ff @(posedge clk) begin
        if (rst)            im <= 8'h00;
        else if (status_we) im <= cp0_wdata[15:8];
    end
    assign im_eff = im[NUM_IRQ-1:0];
`else
    assign im     = 8'h00;
    assign im_eff = '1;
`endif

    assign status_we = cp0_we && (cp0_addr == CP0_STATUS);
    assign irq_pend  = ((irq & im_eff) != '0) && ie && !exl && ex_valid;
    assign unused_ok = ^cp0_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Request arbitration and sequencing
    always_comb begin
        next_state = state;
        take_exc   = 1'b0;
        take_eret  = 1'b0;
        exc_code_n = exc_code;
        case (state)
            IDLE: begin
                if (!stall) begin
                    if (mem_eret) begin
                        take_eret  = 1'b1;
                        next_state = ERET_FLUSH;
                    end else if (ex_valid && ex_ovf) begin
                        take_exc   = 1'b1;
                        exc_code_n = EXC_OV;
                    end else if (ex_valid && ex_ri) begin
                        take_exc   = 1'b1;
                        exc_code_n = EXC_RI;
                    end else if (ex_valid && ex_syscall) begin
                        take_exc   = 1'b1;
                        exc_code_n = EXC_SYS;
                    end else if (irq_pend) begin
                        take_exc   = 1'b1;
                        exc_code_n = EXC_INT;
                    end
                    if (take_exc) next_state = FLUSH;
                end
            end
            FLUSH, ERET_FLUSH: next_state = REDIRECT;
            REDIRECT:          next_state = IDLE;
            default:           next_state = IDLE;
        endcase
    end

    // Registered outputs and CP0 state; controller EXL update overrides mtc0
    always_ff @(posedge clk) begin
        if (rst) begin
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            redirect_pc <= 32'h0;
            busy        <= 1'b0;
            ip          <= '0;
            exc_code    <= 5'd0;
            cap_pc      <= 32'h0;
            target_pc   <= 32'h0;
            ie          <= 1'b0;
            exl         <= 1'b0;
        end else begin
            flush       <= (next_state == FLUSH) || (next_state == ERET_FLUSH);
            pc_redirect <= (next_state == REDIRECT);
            redirect_pc <= (next_state == REDIRECT) ? target_pc : 32'h0;
            busy        <= (next_state != IDLE);
            ip          <= irq;
            if (status_we) begin
                ie  <= cp0_wdata[0];
                exl <= cp0_wdata[1];
            end
            if (take_exc) begin
                cap_pc    <= ex_pc;
                exc_code  <= exc_code_n;
                target_pc <= VECTOR_ADDR;
                exl       <= 1'b1;
            end
            if (take_eret) begin
                target_pc <= epc_q;
                exl       <= 1'b0;
            end
        end
    end

    assign epc_d  = (state == FLUSH) ? cap_pc : epc_q;
    assign status = {16'h0000, im, 6'b000000, exl, ie};

    always_comb begin
        cause                = 32'h0;
        cause[6:2]           = exc_code;
        cause[8 +: NUM_IRQ]  = ip;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt controller for the pipelined MIPS core. It accepts synchronous exceptions from EX, external interrupts and ERET from MEM, and prioritises them. It sequences pipeline flush, the EPC register update (drives the EPC data-input path) and the PC redirect to the handler vector or back to EPC. It also owns the CP0 Status and Cause registers.

Parameters:
VECTOR_ADDR, 32'h0000_0008, handler entry address on any exception or interrupt
NUM_IRQ, 4, number of level-sensitive external interrupt lines (1..8)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
irq  in  NUM_IRQ  external interrupt lines, level, active-high
stall  in  1  pipeline stall; no request accepted while high
ex_pc  in  32  PC of instruction currently in EX
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_ovf  in  1  arithmetic overflow in EX
ex_ri  in  1  reserved instruction in EX
ex_syscall  in  1  syscall in EX
mem_eret  in  1  ERET in MEM
cp0_we  in  1  mtc0 strobe
cp0_addr  in  5  CP0 register index (12 Status, 13 Cause)
cp0_wdata  in  32  mtc0 data
epc_q  in  32  current EPC register value
epc_d  out  32  next-value data for EPC register
flush  out  1  flush IF/ID/EX
pc_redirect  out  1  override next PC
redirect_pc  out  32  redirect target
status  out  32  Status register (bit0 IE, bit1 EXL, bits15:8 IM)
cause  out  32  Cause register (bits6:2 ExcCode, bits(8+NUM_IRQ-1):8 IP)
busy  out  1  controller sequencing; high in any non-IDLE state

Behaviour:
- Clocking: single clk. Reset is synchronous and active-high, and takes priority over everything, including an in-flight sequence.
- Reset values: state IDLE, status=0, cause=0, flush=0, pc_redirect=0, redirect_pc=0, busy=0, internal captured-PC=0.
- epc_d passes epc_q through (the EPC register holds) except in the FLUSH state, where it is the captured PC.
- States: IDLE, FLUSH, ERET_FLUSH, REDIRECT.
- Request evaluation happens only in IDLE with stall=0. Priority, highest first:
  1. mem_eret (older instruction).
  2. ex_ovf, then ex_ri, then ex_syscall; each requires ex_valid.
  3. Interrupt: (irq & IM_eff) != 0 and IE=1 and EXL=0 and ex_valid=1.
- Exception/interrupt accepted at edge N:
  - Capture ex_pc.
  - Cause.ExcCode set to Ov=12, RI=10, Sys=8 or Int=0.
  - EXL set to 1; state -> FLUSH.
- FLUSH, 1 cycle: flush=1, epc_d=captured PC; state -> REDIRECT with redirect target VECTOR_ADDR.
- ERET accepted at edge N:
  - Latch epc_q as target; EXL cleared to 0; state -> ERET_FLUSH.
  - ERET_FLUSH, 1 cycle: flush=1, epc_d=epc_q; state -> REDIRECT.
- REDIRECT, 1 cycle: pc_redirect=1, redirect_pc=target; state -> IDLE. redirect_pc returns to 0 in IDLE.
- Latency: request at cycle N, flush in cycle N+1, redirect in cycle N+2, new request accepted at earliest in cycle N+3.
- Requests and irq changes seen while not in IDLE are ignored. They are not queued; the pipeline re-presents them after refetch.
- Cause.IP bits are updated every cycle from raw irq, independent of state and masks.
- mtc0 to Status writes IE, EXL, IM. If it coincides with an accepted exception or ERET, the controller's EXL update wins; IE/IM still take the mtc0 value. mtc0 to Cause is ignored (read-only).
- An exception concurrent with ERET is dropped; EX is flushed by the ERET sequence.

Optional Feature:
Macro EXC_IRQ_MASK_EN.
- Defined: Status[15:8] IM bits are writable by mtc0; IM_eff = IM[NUM_IRQ-1:0].
- Undefined: IM bits read as 0 and ignore writes; IM_eff is all ones, so IE/EXL alone gate interrupts.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> status=0, cause=0, flush=0, pc_redirect=0, busy=0, epc_d=epc_q.
2. Overflow: ex_valid=1, ex_ovf=1, ex_pc=0x0000_0040 -> next cycle flush=1 and epc_d=0x40; following cycle pc_redirect=1 with redirect_pc=0x8; cause[6:2]=12; status[1]=1.
3. Priority: mem_eret=1 with ex_syscall=1, epc_q=0x100 -> ERET sequence, redirect_pc=0x100, EXL cleared, no Sys code written.
4. Interrupt gating:
   - IE=1, EXL=1, irq=4'b0010 -> no sequence; cause[9]=1.
   - Then mtc0 Status=0x0000FF01 -> interrupt taken, ExcCode=0, EPC receives ex_pc.
5. Stall and busy: ex_syscall held with stall=1 for 3 cycles -> no action; stall drops -> accepted. A second syscall in the REDIRECT cycle is ignored.
6. Reset mid-sequence: rst in the FLUSH cycle -> next cycle state IDLE, pc_redirect=0, status=0. With EXC_IRQ_MASK_EN undefined, an mtc0 IM write reads back 0.
